// File: rtl/fp_pkg.sv
// Float format helpers shared by int_to_floating_point and floating_point_multiplier.
// Format: [sign | EXP_WIDTH exponent | FRAC_WIDTH fraction], hidden lead bit not stored.
`timescale 1ns/1ps
package fp_pkg;

    localparam int unsigned FP32_EXP_WIDTH  = 8;
    localparam int unsigned FP32_FRAC_WIDTH = 23;
    localparam int unsigned FP_FRAC_LSB     = 0;

    function automatic int unsigned fp_bias(input int unsigned exp_width);
        return (32'd1 << (exp_width - 1)) - 32'd1;
    endfunction

    function automatic int unsigned fp_exp_max(input int unsigned exp_width);
        return (32'd1 << exp_width) - 32'd1;
    endfunction

    function automatic int unsigned fp_width(input int unsigned exp_width,
                                             input int unsigned frac_width);
        return 1 + exp_width + frac_width;
    endfunction

    function automatic int unsigned fp_frac_msb(input int unsigned frac_width);
        return frac_width - 1;
    endfunction

    function automatic int unsigned fp_exp_lsb(input int unsigned frac_width);
        return frac_width;
    endfunction

    function automatic int unsigned fp_exp_msb(input int unsigned exp_width,
                                               input int unsigned frac_width);
        return frac_width + exp_width - 1;
    endfunction

    function automatic int unsigned fp_sign_bit(input int unsigned exp_width,
                                                input int unsigned frac_width);
        return frac_width + exp_width;
    endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Combinational leading-one detector: index of the most significant set bit plus a zero flag.
`timescale 1ns/1ps
module leading_one_detector #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     zero
);

    localparam int unsigned POS_W = $clog2(WIDTH);

    always_comb begin
        pos = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) pos = POS_W'(i);
        end
    end

    assign zero = ~|vec;

endmodule

// File: rtl/int_to_floating_point.sv
// Pipelined integer -> float converter, round-to-nearest ties-away, saturates to +/-inf.
// Optional input skid buffer selected by macro INT_TO_FP_SKID_EN.
`timescale 1ns/1ps
module int_to_floating_point
    import fp_pkg::*;
#(
    parameter int unsigned INT_WIDTH  = 32,
    parameter int unsigned SIGNED_IN  = 1,
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 23
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [INT_WIDTH-1:0]                        int_i,
    input  logic                                        valid_i,
    output logic                                        ready_o,
    output logic [fp_width(EXP_WIDTH, FRAC_WIDTH)-1:0]  fp_o,
    output logic                                        valid_o,
    input  logic                                        ready_i
);

    localparam int unsigned FPW      = fp_width(EXP_WIDTH, FRAC_WIDTH);
    localparam int unsigned BIAS     = fp_bias(EXP_WIDTH);
    localparam int unsigned EXP_MAX  = fp_exp_max(EXP_WIDTH);
    localparam int unsigned SIGN_BIT = fp_sign_bit(EXP_WIDTH, FRAC_WIDTH);
    localparam int unsigned EXP_MSB  = fp_exp_msb(EXP_WIDTH, FRAC_WIDTH);
    localparam int unsigned EXP_LSB  = fp_exp_lsb(FRAC_WIDTH);
    localparam int unsigned FRAC_MSB = fp_frac_msb(FRAC_WIDTH);
    localparam int unsigned PW       = $clog2(INT_WIDTH);

    logic                 adv;
    logic                 pipe_valid;
    logic [INT_WIDTH-1:0] pipe_data;

    assign adv = !valid_o || ready_i;

`ifdef INT_TO_FP_SKID_EN
    logic [INT_WIDTH-1:0] skid_data [2];
    logic [1:0]           skid_cnt;
    logic [1:0]           skid_cnt_next;
    logic                 skid_push;
    logic                 skid_pop;
    logic                 ready_q;

    // Empty buffer is bypassed so latency is unchanged; buffered entries always go first.
    always_comb begin
        pipe_valid = valid_i;
        pipe_data  = int_i;
        if (skid_cnt != 2'd0) begin
            pipe_valid = 1'b1;
            pipe_data  = skid_data[0];
        end
        skid_pop      = (skid_cnt != 2'd0) && adv;
        skid_push     = valid_i && ready_q && !((skid_cnt == 2'd0) && adv);
        skid_cnt_next = skid_cnt + 2'(skid_push) - 2'(skid_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_cnt     <= 2'd0;
            ready_q      <= 1'b1;
            skid_data[0] <= '0;
            skid_data[1] <= '0;
        end else begin
            skid_cnt <= skid_cnt_next;
            ready_q  <= (skid_cnt_next != 2'd2);
            if (skid_pop && skid_push) begin
                skid_data[0] <= int_i;
            end else if (skid_pop) begin
                skid_data[0] <= skid_data[1];
            end else if (skid_push) begin
                skid_data[skid_cnt[0]] <= int_i;
            end
        end
    end

    assign ready_o = ready_q;
`else
    assign pipe_valid = valid_i;
    assign pipe_data  = int_i;
    assign ready_o    = adv;
`endif

    logic                 in_sign;
    logic [INT_WIDTH-1:0] in_mag;
    logic [PW-1:0]        lod_pos;
    logic                 lod_zero;

    assign in_sign = (SIGNED_IN != 0) && pipe_data[INT_WIDTH-1];
    assign in_mag  = in_sign ? -pipe_data : pipe_data;

    leading_one_detector #(
        .WIDTH (INT_WIDTH)
    ) u_lod (
        .vec  (in_mag),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    logic                 s1_valid;
    logic                 s1_sign;
    logic                 s1_zero;
    logic [INT_WIDTH-1:0] s1_mag;
    logic [PW-1:0]        s1_pos;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b1;
            s1_mag   <= '0;
            s1_pos   <= '0;
        end else if (adv) begin
            s1_valid <= pipe_valid;
            s1_sign  <= in_sign;
            s1_zero  <= lod_zero;
            s1_mag   <= in_mag;
            s1_pos   <= lod_pos;
        end
    end

    // Lead one lands just above {frac, round}; the cast drops it along with everything below round.
    logic [FRAC_WIDTH:0] s1_norm;
    assign s1_norm = (FRAC_WIDTH + 1)'(({s1_mag, {(FRAC_WIDTH + 1){1'b0}}}
                     << (INT_WIDTH - 1 - 32'(s1_pos))) >> (INT_WIDTH - 1));

    logic                  s2_valid;
    logic                  s2_sign;
    logic                  s2_zero;
    logic [FRAC_WIDTH-1:0] s2_frac;
    logic                  s2_rnd;
    logic [31:0]           s2_exp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b1;
            s2_frac  <= '0;
            s2_rnd   <= 1'b0;
            s2_exp   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_frac  <= s1_norm[FRAC_WIDTH:1];
            s2_rnd   <= s1_norm[0];
            s2_exp   <= 32'(s1_pos) + BIAS;
        end
    end

    logic                  carry;
    logic [FRAC_WIDTH-1:0] frac_r;
    logic [31:0]           exp_r;
    logic [FPW-1:0]        fp_next;

    // A rounding carry wraps frac_r to zero, which is exactly the renormalised fraction.
    always_comb begin
        {carry, frac_r} = {1'b0, s2_frac} + (FRAC_WIDTH + 1)'(s2_rnd);
        exp_r           = s2_exp + 32'(carry);
        fp_next         = '0;
        if (!s2_zero) begin
            fp_next[SIGN_BIT] = s2_sign;
            if (exp_r >= EXP_MAX) begin
                fp_next[EXP_MSB:EXP_LSB] = '1;
            end else begin
                fp_next[EXP_MSB:EXP_LSB]      = exp_r[EXP_WIDTH-1:0];
                fp_next[FRAC_MSB:FP_FRAC_LSB] = frac_r;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            fp_o    <= '0;
        end else if (adv) begin
            valid_o <= s2_valid;
            fp_o    <= fp_next;
        end
    end

endmodule
